dot_product_sequencer: RTL and testbench
========================================

// Module: dot_product_sequencer
// PURPOSE
//  Sequences the MultAccumulate datapath to compute one neuron pre-activation:
//  result = bias + sum(A[i]*B[i]), i=0..len-1, IEEE-754 single precision.
//  Reads operand pairs from two synchronous vector RAMs, holds MAC inputs stable
//  for the FPU latency, feeds each MAC result back as the next accumulator.
//  Sits between the MLP layer controller (start/result handshake) and the MAC.
// PARAMETERS
//  ADDR_W       8   vector RAM address width; max vector length 2**ADDR_W
//  MAC_LATENCY  4   CLK cycles from stable MAC inputs to valid mac_result (>=1)
// PORTS
//  CLK           in   1         clock, rising edge
//  RST           in   1         asynchronous reset, active-high
//  start         in   1         pulse: begin dot product (sampled only in IDLE)
//  len           in   ADDR_W+1  vector length, sampled with start; 0 allowed
//  bias          in   32        initial accumulator, sampled with start
//  busy          out  1         high in every state except IDLE
//  mem_en        out  1         RAM read enable (both RAMs)
//  mem_addr      out  ADDR_W    RAM read address (both RAMs)
//  mem_a_data    in   32        RAM A read data, valid 1 cycle after mem_en
//  mem_b_data    in   32        RAM B read data, valid 1 cycle after mem_en
//  mac_opA       out  32        to MultAccumulate opA (registered)
//  mac_opB       out  32        to MultAccumulate opB (registered)
//  mac_acc       out  32        to MultAccumulate accumulator (registered)
//  mac_result    in   32        from MultAccumulate result
//  result        out  32        final dot product, stable while result_valid
//  result_valid  out  1         result available
//  result_ready  in   1         consumer accepts result when valid&ready
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy, mem_en, result_valid=0;
//   mem_addr, mac_opA, mac_opB, mac_acc, result, idx, wait counter = 0.
//  FSM (all transitions on rising CLK):
//   IDLE : start&len!=0 -> latch len, acc<=bias, idx<=0 -> FETCH.
//          start&len==0 -> result<=bias -> DONE. start otherwise ignored.
//   FETCH: mem_en=1, mem_addr=idx for exactly one cycle -> ISSUE.
//   ISSUE: mac_opA<=mem_a_data, mac_opB<=mem_b_data, mac_acc<=acc,
//          cnt<=MAC_LATENCY -> WAIT.
//   WAIT : cnt decrements each cycle; mac_* held constant. At cnt==1:
//          acc<=mac_result; if idx==len-1 {result<=mac_result -> DONE}
//          else {idx<=idx+1 -> FETCH}.
//   DONE : result_valid=1, result held; valid&ready -> IDLE (valid drops
//          next cycle). start in DONE ignored, not queued.
//  Per-element cost: MAC_LATENCY+2 cycles; total from start to result_valid
//   = 1 + len*(MAC_LATENCY+2) cycles (len==0: 1 cycle).
//  mem_en low in all states except FETCH; mem_addr holds last value otherwise.
//  len==2**ADDR_W: idx reaches 2**ADDR_W-1, never wraps; no extra read issued.
//  len/bias changes while busy have no effect (latched copies used).
//  RST mid-operation aborts immediately; partial accumulator discarded, no
//   result_valid. No floating-point exception handling; NaN/Inf pass through.
//  start and result_ready asserted same cycle in DONE: accept result only.
// TESTING (bench uses behavioural MAC: result = opA*opB+acc after MAC_LATENCY)
//  T1 len=2, bias=0x00000000, A={0x3F800000,0x40000000}(1,2), B={0x40400000,
//     0x3F800000}(3,1) -> result=0x40A00000 (5.0) at cycle 1+2*(MAC_LATENCY+2).
//  T2 len=0, bias=0x40400000 -> result_valid next cycle, result=0x40400000,
//     no mem_en pulse.
//  T3 len=3, bias=0x3F800000, A=B={1,1,1} -> result=0x40800000 (4.0); check
//     mem_addr sequence 0,1,2 with exactly one mem_en pulse each.
//  T4 hold result_ready=0 for 10 cycles in DONE, pulse start -> result and
//     valid stable, start ignored; ready=1 -> IDLE, busy=0 next cycle.
//  T5 assert RST during WAIT of element 1 of len=4 -> all outputs 0 at once;
//     new start len=1,A=B={2.0} bias=0 -> result=0x40800000.
//  T6 len=2**ADDR_W, all elements 1.0, bias 0 -> result=float(2**ADDR_W),
//     last mem_addr=2**ADDR_W-1, no address wrap.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// Dot product sequencer: walks two vector RAMs and drives a MAC datapath
// to produce bias + sum(A[i]*B[i]) as one neuron pre-activation.
module dot_product_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int MAC_LATENCY = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [31:0]       bias,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_a_data,
    input  logic [31:0]       mem_b_data,
    output logic [31:0]       mac_opA,
    output logic [31:0]       mac_opB,
    output logic [31:0]       mac_acc,
    input  logic [31:0]       mac_result,
    output logic [31:0]       result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(MAC_LATENCY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       acc_q, acc_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [31:0]       macc_q, macc_d;
    logic [31:0]       res_q, res_d;
    logic              last_elem;

    // Widened compare so len == 2**ADDR_W ends at idx 2**ADDR_W-1 without wrap.
    assign last_elem = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        macc_d  = macc_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        acc_d   = bias;
                        idx_d   = '0;
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = bias;
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                opa_d   = mem_a_data;
                opb_d   = mem_b_data;
                macc_d  = acc_q;
                cnt_d   = CNT_W'(MAC_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    acc_d = mac_result;
                    cnt_d = '0;
                    if (last_elem) begin
                        res_d   = mac_result;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        addr_d  = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any dot product in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            macc_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            macc_q  <= macc_d;
            res_q   <= res_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign mem_en       = (state_q == S_FETCH);
    assign mem_addr     = addr_q;
    assign mac_opA      = opa_q;
    assign mac_opB      = opb_q;
    assign mac_acc      = macc_q;
    assign result       = res_q;
    assign result_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: behavioural RAMs and MAC, scoreboard
// queue of expected results popped by a result monitor.
module tb_dot_product_sequencer;

    localparam int AW  = 8;
    localparam int LAT = 4;
    localparam int N   = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW:0]   len;
    logic [31:0]   bias;
    logic          busy;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_a_data;
    logic [31:0]   mem_b_data;
    logic [31:0]   mac_opA;
    logic [31:0]   mac_opB;
    logic [31:0]   mac_acc;
    logic [31:0]   mac_result;
    logic [31:0]   result;
    logic          result_valid;
    logic          result_ready;

    dot_product_sequencer #(.ADDR_W(AW), .MAC_LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .bias(bias),
        .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
        .mac_opA(mac_opA), .mac_opB(mac_opB), .mac_acc(mac_acc),
        .mac_result(mac_result), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int addr_log[$];

    logic [31:0] ram_a [N];
    logic [31:0] ram_b [N];
    logic [31:0] pipe [LAT-1];

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'({3'b0, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge CLK) begin
        if (mem_en) begin
            mem_a_data <= ram_a[mem_addr];
            mem_b_data <= ram_b[mem_addr];
        end
    end

    always @(posedge CLK) begin
        pipe[0] <= r2f(f2r(mac_opA) * f2r(mac_opB) + f2r(mac_acc));
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_result = pipe[LAT-2];

    always @(negedge CLK) begin
        if (mem_en) addr_log.push_back(int'(mem_addr));
        if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL result_unexpected: got 0x%0h expected none",
                         result);
            end else begin
                check("result", 64'(result), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input int n, input logic [31:0] a,
                        input logic [31:0] b);
        for (int i = 0; i < n; i++) begin
            ram_a[i] = a;
            ram_b[i] = b;
        end
    endtask

    task automatic run(input int n, input logic [31:0] b,
                       input logic [31:0] expv, input string tag);
        int cyc;
        exp_q.push_back(expv);
        addr_log.delete();
        start = 1'b1;
        len   = (AW+1)'(n);
        bias  = b;
        tick();
        start = 1'b0;
        len   = ~len;
        bias  = ~b;
        cyc   = 1;
        while (!result_valid && cyc < 5000) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(1 + n * (LAT + 2)));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   64'(busy), 64'd0);
        check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check({tag, "_addr"},   64'(mem_addr), 64'd0);
        check({tag, "_opA"},    64'(mac_opA), 64'd0);
        check({tag, "_opB"},    64'(mac_opB), 64'd0);
        check({tag, "_acc"},    64'(mac_acc), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_valid"},  64'(result_valid), 64'd0);
    endtask

    initial begin
        int bad;
        RST = 1'b1;
        start = 1'b0;
        len = '0;
        bias = '0;
        result_ready = 1'b1;
        fill(N, 32'h0, 32'h0);
        repeat (2) tick();
        check_zero("reset");
        RST = 1'b0;
        tick();

        // T1: 1*3 + 2*1 = 5.0
        ram_a[0] = 32'h3F800000; ram_a[1] = 32'h40000000;
        ram_b[0] = 32'h40400000; ram_b[1] = 32'h3F800000;
        run(2, 32'h0, 32'h40A00000, "t1");
        tick();
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_reads", 64'(addr_log.size()), 64'd2);

        // T2: empty vector returns bias
        run(0, 32'h40400000, 32'h40400000, "t2");
        tick();
        check("t2_reads", 64'(addr_log.size()), 64'd0);
        check("t2_busy_after", 64'(busy), 64'd0);

        // T3: 1 + 1+1+1 = 4.0, addresses 0,1,2
        fill(3, 32'h3F800000, 32'h3F800000);
        run(3, 32'h3F800000, 32'h40800000, "t3");
        tick();
        check("t3_reads", 64'(addr_log.size()), 64'd3);
        for (int i = 0; i < addr_log.size(); i++)
            check("t3_addr", 64'(addr_log[i]), 64'(i));

        // T4: back-pressure in DONE, start pulse ignored
        fill(1, 32'h3F800000, 32'h3F800000);
        result_ready = 1'b0;
        run(1, 32'h3F800000, 32'h40000000, "t4");
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start = 1'b1;
                len = 9'd2;
            end
            tick();
            start = 1'b0;
            check("t4_valid_hold", 64'(result_valid), 64'd1);
            check("t4_result_hold", 64'(result), 64'h40000000);
        end
        result_ready = 1'b1;
        tick();
        check("t4_busy_after", 64'(busy), 64'd0);
        check("t4_valid_after", 64'(result_valid), 64'd0);
        tick();
        check("t4_start_not_queued", 64'(busy), 64'd0);

        // T5: reset during WAIT of element 1, then a fresh run
        fill(4, 32'h3F800000, 32'h3F800000);
        start = 1'b1;
        len = 9'd4;
        bias = 32'h0;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("t5_busy_mid", 64'(busy), 64'd1);
        check("t5_addr_mid", 64'(mem_addr), 64'd1);
        check("t5_opA_mid", 64'(mac_opA), 64'h3F800000);
        RST = 1'b1;
        #1;
        check_zero("t5_abort");
        tick();
        RST = 1'b0;
        tick();
        ram_a[0] = 32'h40000000;
        ram_b[0] = 32'h40000000;
        run(1, 32'h0, 32'h40800000, "t5");
        tick();

        // T6: full-length vector of ones, 256.0
        fill(N, 32'h3F800000, 32'h3F800000);
        run(N, 32'h0, 32'h43800000, "t6");
        tick();
        check("t6_reads", 64'(addr_log.size()), 64'(N));
        check("t6_last_addr", 64'(addr_log[$]), 64'(N - 1));
        bad = 0;
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] != i) bad++;
        check("t6_addr_seq", 64'(bad), 64'd0);

        repeat (2) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
